// File: rtl/reg_arb_pkg.sv
// rtl/reg_arb_pkg.sv - shared state encodings and defaults for the register write arbiter
package reg_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_GRANT  = 2'd1,
    ARB_LOCKED = 2'd2
  } arb_state_e;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_DATA_W   = 1;
  localparam int DEF_LOCK_MAX = 4;

  // Round-robin successor of an index, wrapping explicitly for non-power-of-2 counts.
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// rtl/reg_write_arbiter_if.sv - requester bundle and shared-register drive for the arbiter
interface reg_write_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 1
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        lock;
  logic [N_REQ*DATA_W-1:0] wdata;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        ack;
  logic                    reg_en;
  logic [DATA_W-1:0]       reg_d;
  logic                    busy;

  modport master (
    output req, lock, wdata,
    input  gnt, ack, reg_en, reg_d, busy
  );

  modport slave (
    input  req, lock, wdata,
    output gnt, ack, reg_en, reg_d, busy
  );
endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating priority encoder starting at ptr
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  input  logic [N_REQ-1:0] mask,
  output logic [N_REQ-1:0] onehot,
  output logic [PW-1:0]    idx,
  output logic             found
);
  logic [N_REQ-1:0] eff;
  int               j;

  assign eff = req & ~mask;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    j      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && eff[j]) begin
        found     = 1'b1;
        idx       = PW'(j);
        onehot[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin owner of a shared enable-gated register with bounded lock
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int LOCK_MAX = DEF_LOCK_MAX
) (
  input  logic               clk,
  input  logic               rst_n,
  reg_write_arbiter_if.slave bus
);
  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] LOCK_MAX_C = CW'(LOCK_MAX);

  arb_state_e        state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [PW-1:0]     idx_q, idx_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] reg_d_q, reg_d_d;

  logic              owner_vld, lock_held, extend, timed_out, others;
  logic [N_REQ-1:0]  pick_mask, pick_onehot;
  logic [PW-1:0]     pick_idx;
  logic              pick_found;

  assign owner_vld = |gnt_q;
  assign lock_held = owner_vld && bus.req[idx_q] && bus.lock[idx_q];
  assign extend    = lock_held && (cnt_q < LOCK_MAX_C);
  assign timed_out = lock_held && (cnt_q >= LOCK_MAX_C);
  assign others    = |(bus.req & ~gnt_q);
  // A timed-out owner only steps aside when someone else is actually waiting.
  assign pick_mask = (timed_out && others) ? gnt_q : '0;

  rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_pick (
    .req    (bus.req),
    .ptr    (ptr_q),
    .mask   (pick_mask),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      reg_d_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      reg_d_q <= reg_d_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    reg_d_d = reg_d_q;
    if (extend) begin
      state_d = ARB_LOCKED;
      cnt_d   = cnt_q + CW'(1);
      reg_d_d = bus.wdata[int'(idx_q)*DATA_W +: DATA_W];
    end else if (pick_found) begin
      state_d = ARB_GRANT;
      gnt_d   = pick_onehot;
      idx_d   = pick_idx;
      ptr_d   = PW'(rr_next(int'(pick_idx), N_REQ));
      cnt_d   = CW'(1);
      reg_d_d = bus.wdata[int'(pick_idx)*DATA_W +: DATA_W];
    end else begin
      state_d = ARB_IDLE;
      gnt_d   = '0;
      cnt_d   = '0;
    end
  end

  always_comb begin
    bus.gnt    = gnt_q;
    bus.ack    = gnt_q;
    bus.reg_en = |gnt_q;
    bus.reg_d  = reg_d_q;
    bus.busy   = (state_q != ARB_IDLE);
  end
endmodule
